// File: rtl/ahb3lite_burst_master.sv
// AHB3-Lite burst master: turns one burst command into a pipelined AHB-Lite transfer
// sequence with wrap/increment addressing, wait-state stalls and error abort.
module ahb3lite_burst_master #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned MAX_LEN    = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [HADDR_SIZE-1:0] cmd_addr,
    input  logic [2:0]            cmd_hburst,
    input  logic [2:0]            cmd_hsize,
    input  logic [3:0]            cmd_hprot,
    input  logic [4:0]            cmd_len,
    input  logic [HDATA_SIZE-1:0] wdata,
    output logic                  wdata_pop,
    output logic [HDATA_SIZE-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  done,
    output logic                  err,
    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_LAST  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] HB_INCR   = 3'b001;

    logic [1:0]            state_q, state_d;
    logic [1:0]            htrans_q, htrans_d;
    logic                  hsel_q, hsel_d;
    logic [HADDR_SIZE-1:0] haddr_q, haddr_d;
    logic [HDATA_SIZE-1:0] hwdata_q, hwdata_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [2:0]            hburst_q, hburst_d;
    logic [3:0]            hprot_q, hprot_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [HDATA_SIZE-1:0] rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      beats_left_q, beats_left_d;
    logic                  wrap_q, wrap_d;
    logic [HADDR_SIZE-1:0] wrap_mask_q, wrap_mask_d;
    logic                  dphase_q, dphase_d;
    logic                  dphase_rd_q, dphase_rd_d;

    logic [2:0]            cmd_size_c;
    logic [CNT_W-1:0]      cmd_beats_c;
    logic                  cmd_wrap_c;
    logic [HADDR_SIZE-1:0] step_c;
    logic [HADDR_SIZE-1:0] incr_addr_c;
    logic [HADDR_SIZE-1:0] next_addr_c;
    logic                  cross_1k_c;
    logic                  accept_c;
    logic                  err_first_c;

    // Command decode: clamp size, derive beat count and wrap flag
    always_comb begin
        cmd_size_c = (cmd_hsize > 3'b010) ? 3'b010 : cmd_hsize;
        cmd_wrap_c = (cmd_hburst[2:1] != 2'b00) && !cmd_hburst[0];
        case (cmd_hburst)
            3'b000: cmd_beats_c = CNT_W'(1);
            3'b001: begin
                if (cmd_len == 5'd0) begin
                    cmd_beats_c = CNT_W'(1);
                end else if (32'(cmd_len) > MAX_LEN) begin
                    cmd_beats_c = CNT_W'(MAX_LEN);
                end else begin
                    cmd_beats_c = CNT_W'(cmd_len);
                end
            end
            3'b010, 3'b011: cmd_beats_c = CNT_W'(4);
            3'b100, 3'b101: cmd_beats_c = CNT_W'(8);
            default:        cmd_beats_c = CNT_W'(16);
        endcase
    end

    // Next beat address; wrap bursts keep the bits above the wrap boundary
    always_comb begin
        step_c      = HADDR_SIZE'(1) << hsize_q;
        incr_addr_c = haddr_q + step_c;
        next_addr_c = wrap_q ? ((haddr_q & ~wrap_mask_q) | (incr_addr_c & wrap_mask_q))
                             : incr_addr_c;
        cross_1k_c  = !wrap_q && (next_addr_c[9:0] == 10'd0);
    end

    assign accept_c    = htrans_q[1] & HREADY;
    assign err_first_c = dphase_q & HRESP & ~HREADY;

    always_comb begin
        state_d       = state_q;
        htrans_d      = htrans_q;
        hsel_d        = hsel_q;
        haddr_d       = haddr_q;
        hwdata_d      = hwdata_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        hburst_d      = hburst_q;
        hprot_d       = hprot_q;
        cmd_ready_d   = cmd_ready_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        beats_left_d  = beats_left_q;
        wrap_d        = wrap_q;
        wrap_mask_d   = wrap_mask_q;
        dphase_d      = dphase_q;
        dphase_rd_d   = dphase_rd_q;

        if (HREADY) begin
            dphase_d    = htrans_q[1];
            dphase_rd_d = ~hwrite_q;
        end
        if (dphase_q && dphase_rd_q && HREADY && !HRESP) begin
            rdata_d       = HRDATA;
            rdata_valid_d = 1'b1;
        end
        if (accept_c && hwrite_q) begin
            hwdata_d = wdata;
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    hwrite_d     = cmd_write;
                    haddr_d      = cmd_addr;
                    hsize_d      = cmd_size_c;
                    hburst_d     = cmd_hburst;
                    hprot_d      = cmd_hprot;
                    wrap_d       = cmd_wrap_c;
                    wrap_mask_d  = (HADDR_SIZE'(cmd_beats_c) << cmd_size_c) - HADDR_SIZE'(1);
                    beats_left_d = cmd_beats_c - CNT_W'(1);
                    htrans_d     = HT_NONSEQ;
                    hsel_d       = 1'b1;
                    cmd_ready_d  = 1'b0;
                    state_d      = ST_BURST;
                end
            end
            ST_BURST: begin
                if (err_first_c) begin
                    htrans_d = HT_IDLE;
                    hsel_d   = 1'b0;
                    state_d  = ST_ERR;
                end else if (HREADY) begin
                    if (beats_left_q == CNT_W'(0)) begin
                        htrans_d = HT_IDLE;
                        hsel_d   = 1'b0;
                        state_d  = ST_LAST;
                    end else begin
                        haddr_d      = next_addr_c;
                        beats_left_d = beats_left_q - CNT_W'(1);
                        // A 1KB crossing restarts the burst as undefined-length INCR
                        if (cross_1k_c) begin
                            htrans_d = HT_NONSEQ;
                            hburst_d = HB_INCR;
                        end else begin
                            htrans_d = HT_SEQ;
                        end
                    end
                end
            end
            ST_LAST: begin
                if (err_first_c) begin
                    state_d = ST_ERR;
                end else if (HREADY) begin
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_ERR: begin
                htrans_d = HT_IDLE;
                hsel_d   = 1'b0;
                if (HREADY) begin
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            htrans_q      <= HT_IDLE;
            hsel_q        <= 1'b0;
            haddr_q       <= '0;
            hwdata_q      <= '0;
            hwrite_q      <= 1'b0;
            hsize_q       <= 3'b000;
            hburst_q      <= 3'b000;
            hprot_q       <= 4'b0000;
            cmd_ready_q   <= 1'b1;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            beats_left_q  <= '0;
            wrap_q        <= 1'b0;
            wrap_mask_q   <= '0;
            dphase_q      <= 1'b0;
            dphase_rd_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            htrans_q      <= htrans_d;
            hsel_q        <= hsel_d;
            haddr_q       <= haddr_d;
            hwdata_q      <= hwdata_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            hburst_q      <= hburst_d;
            hprot_q       <= hprot_d;
            cmd_ready_q   <= cmd_ready_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
            beats_left_q  <= beats_left_d;
            wrap_q        <= wrap_d;
            wrap_mask_q   <= wrap_mask_d;
            dphase_q      <= dphase_d;
            dphase_rd_q   <= dphase_rd_d;
        end
    end

    // The write pop tracks address acceptance, which depends on this cycle's HREADY
    assign wdata_pop   = accept_c & hwrite_q;
    assign cmd_ready   = cmd_ready_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign HSEL        = hsel_q;
    assign HADDR       = haddr_q;
    assign HWDATA      = hwdata_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = hsize_q;
    assign HBURST      = hburst_q;
    assign HPROT       = hprot_q;
    assign HTRANS      = htrans_q;
    assign HMASTLOCK   = 1'b0;

endmodule

// File: tb/tb_ahb3lite_burst_master.sv
// Randomized bench for ahb3lite_burst_master: an AHB slave model with wait states and
// errors, checked against a burst-level address/data reference model.
module tb_ahb3lite_burst_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_hburst, cmd_hsize;
    logic [3:0]  cmd_hprot;
    logic [4:0]  cmd_len;
    logic [31:0] wdata, rdata, HADDR, HWDATA, HRDATA;
    logic        wdata_pop, rdata_valid, done, err;
    logic        HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    always #5 HCLK = ~HCLK;

    ahb3lite_burst_master #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MAX_LEN(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_hburst(cmd_hburst), .cmd_hsize(cmd_hsize),
        .cmd_hprot(cmd_hprot), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_pop(wdata_pop), .rdata(rdata), .rdata_valid(rdata_valid),
        .done(done), .err(err),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] wlist[$];
    logic [31:0] rlist[$];
    logic [31:0] alist[$];
    logic [1:0]  tlist[$];
    logic [31:0] ref_q[$];
    int          ws_plan[$];
    logic [31:0] exp_addr[$];
    logic [1:0]  exp_trans[$];
    logic [2:0]  exp_burst[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int beats_of(input logic [2:0] hb, input logic [4:0] len);
        case (hb)
            3'b000:         return 1;
            3'b001:         return (len == 5'd0) ? 1 : ((len > 5'd16) ? 16 : int'(len));
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            default:        return 16;
        endcase
    endfunction

    // Reference: list of beat addresses, HTRANS and HBURST per address phase
    task automatic build_model(input logic [31:0] addr, input logic [2:0] hb,
                               input logic [2:0] sz, input int n);
        logic [31:0] step, bound, base, a;
        logic        wrap, crossed;
        logic [1:0]  t;
        step    = 32'd1 << sz;
        wrap    = (hb == 3'b010) || (hb == 3'b100) || (hb == 3'b110);
        bound   = 32'(n) * step;
        base    = addr - (addr % bound);
        crossed = 1'b0;
        exp_addr.delete(); exp_trans.delete(); exp_burst.delete();
        for (int i = 0; i < n; i++) begin
            if (wrap) a = base + ((addr - base + 32'(i) * step) % bound);
            else      a = addr + 32'(i) * step;
            if (i > 0 && !wrap && a[9:0] == 10'd0) begin
                crossed = 1'b1;
                t = 2'b10;
            end else begin
                t = (i == 0) ? 2'b10 : 2'b11;
            end
            exp_addr.push_back(a);
            exp_trans.push_back(t);
            exp_burst.push_back(crossed ? 3'b001 : hb);
        end
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    // Issue one command and act as the slave until done (called at a negedge)
    task automatic run_burst(input logic wr, input logic [31:0] addr, input logic [2:0] hb,
                             input logic [2:0] hs, input logic [3:0] prot,
                             input logic [4:0] len, input int max_ws, input int err_beat);
        int n, cyc, acc, wptr, dph_beat, nb, ws_left, total_ws;
        logic [2:0]  eff;
        logic [31:0] dph_addr, na, exp_rd, prev_addr;
        logic [1:0]  prev_trans;
        logic finished, dph_valid, errph, first_err, exp_rv, exp_done, stall_prev;
        logic new_dph, pop_pending;
        eff = (hs > 3'b010) ? 3'b010 : hs;
        n   = beats_of(hb, len);
        build_model(addr, hb, eff, n);
        while (wlist.size() < n) wlist.push_back($urandom);
        rlist.delete(); alist.delete(); tlist.delete();
        acc = 0; wptr = 0; dph_beat = 0; ws_left = 0; total_ws = 0; cyc = 0;
        dph_addr = '0; prev_addr = '0; prev_trans = '0; exp_rd = '0;
        finished = 0; dph_valid = 0; errph = 0; exp_rv = 0; exp_done = 0;
        stall_prev = 0; pop_pending = 0;
        cmd_write = wr; cmd_addr = addr; cmd_hburst = hb; cmd_hsize = hs;
        cmd_hprot = prot; cmd_len = len; cmd_valid = 1'b1; wdata = wlist[0];
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        @(negedge HCLK);
        cmd_valid = 1'b0;
        while (!finished && cyc < 300) begin
            cyc++;
            if (pop_pending) begin
                wptr++;
                wdata = (wptr < n) ? wlist[wptr] : 32'hDEAD_BEEF;
                pop_pending = 0;
            end
            check("rvalid", 64'(rdata_valid), 64'(exp_rv));
            if (exp_rv) check("rdata", 64'(rdata), 64'(exp_rd));
            check("done", 64'(done), 64'(exp_done));
            check("no_busy", 64'(HTRANS == 2'b01), 64'(0));
            if (exp_done) begin
                cmd_valid = 1'b0;
                check("err", 64'(err), 64'(err_beat != 0));
                check("cmd_ready_at_done", 64'(cmd_ready), 64'(1));
                check("beats", 64'(acc), 64'((err_beat != 0) ? err_beat : n));
                if (err_beat == 0) check("latency", 64'(cyc), 64'(n + 2 + total_ws));
                finished = 1;
            end else begin
                exp_rv = 0;
                check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
                cmd_valid = 1'($urandom_range(0, 1));
                if (stall_prev) begin
                    check("haddr_hold", 64'(HADDR), 64'(prev_addr));
                    check("htrans_hold", 64'(HTRANS), 64'(prev_trans));
                end
                first_err = 0;
                HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
                if (dph_valid) begin
                    if (errph) begin
                        HRESP = 1'b1;
                        check("idle_after_err", 64'(HTRANS), 64'(0));
                    end else if (err_beat != 0 && dph_beat == err_beat - 1) begin
                        HREADY = 1'b0; HRESP = 1'b1; first_err = 1;
                    end else if (ws_left > 0) begin
                        HREADY = 1'b0; ws_left--; total_ws++;
                    end
                    if (!wr) HRDATA = mem[dph_addr[11:2]];
                    else check("hwdata", 64'(HWDATA), 64'(wlist[dph_beat]));
                end
                #1;
                check("wdata_pop", 64'(wdata_pop), 64'(HREADY && HTRANS[1] && wr));
                new_dph = 0; na = '0; nb = 0;
                if (HREADY && HTRANS[1]) begin
                    check("beat_limit", 64'(acc < n && !errph), 64'(1));
                    if (acc < n) begin
                        check("haddr", 64'(HADDR), 64'(exp_addr[acc]));
                        check("htrans", 64'(HTRANS), 64'(exp_trans[acc]));
                        check("hburst", 64'(HBURST), 64'(exp_burst[acc]));
                        check("hsel", 64'(HSEL), 64'(1));
                        check("hwrite", 64'(HWRITE), 64'(wr));
                        check("hsize", 64'(HSIZE), 64'(eff));
                        check("hprot", 64'(HPROT), 64'(prot));
                        alist.push_back(HADDR);
                        tlist.push_back(HTRANS);
                    end
                    new_dph = 1; na = HADDR; nb = acc; acc++;
                    if (wr) pop_pending = 1;
                end
                if (HREADY && dph_valid) begin
                    if (HRESP) begin
                        exp_done = 1;
                    end else begin
                        if (wr) mem[dph_addr[11:2]] = wlist[dph_beat];
                        else begin
                            exp_rv = 1; exp_rd = HRDATA; rlist.push_back(HRDATA);
                        end
                        if (dph_beat == n - 1) exp_done = 1;
                    end
                    dph_valid = 0;
                end
                if (first_err) errph = 1;
                stall_prev = !HREADY && !first_err;
                prev_addr  = HADDR;
                prev_trans = HTRANS;
                if (new_dph) begin
                    dph_valid = 1; dph_beat = nb; dph_addr = na;
                    ws_left = (nb < ws_plan.size()) ? ws_plan[nb] : int'($urandom_range(0, max_ws));
                end
                @(negedge HCLK);
            end
        end
        check("burst_completed", 64'(finished), 64'(1));
        HREADY = 1'b1; HRESP = 1'b0; cmd_valid = 1'b0;
        ws_plan.delete();
        wlist.delete();
        if (!finished) do_reset();
    endtask

    task automatic check_list(input string tag, input logic use_r);
        check({tag, "_len"}, 64'(use_r ? rlist.size() : alist.size()), 64'(ref_q.size()));
        for (int i = 0; i < ref_q.size(); i++)
            check(tag, 64'(use_r ? rlist[i] : alist[i]), 64'(ref_q[i]));
    endtask

    initial begin
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_hburst = '0; cmd_hsize = '0; cmd_hprot = '0; cmd_len = '0; wdata = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        repeat (2) @(negedge HCLK);
        check("rst_htrans", 64'(HTRANS), 64'(0));
        check("rst_hsel", 64'(HSEL), 64'(0));
        check("rst_haddr", 64'(HADDR), 64'(0));
        check("rst_hwdata", 64'(HWDATA), 64'(0));
        check("rst_ctrl", 64'({HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK}), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_pulses", 64'({wdata_pop, rdata_valid, done, err}), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        HRESETn = 1'b1;
        @(negedge HCLK);

        wlist = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        run_burst(1'b1, 32'h0, 3'b011, 3'b010, 4'h3, 5'd0, 0, 0);
        ref_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        check_list("incr4_wr_addr", 1'b0);
        run_burst(1'b0, 32'h0, 3'b011, 3'b010, 4'h3, 5'd0, 0, 0);
        ref_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        check_list("incr4_rd_data", 1'b1);

        run_burst(1'b0, 32'h38, 3'b010, 3'b010, 4'h1, 5'd0, 0, 0);
        ref_q = '{32'h38, 32'h3C, 32'h30, 32'h34};
        check_list("wrap4_addr", 1'b0);
        run_burst(1'b0, 32'h1C, 3'b100, 3'b001, 4'h1, 5'd0, 0, 0);
        ref_q = '{32'h1C, 32'h1E, 32'h10, 32'h12, 32'h14, 32'h16, 32'h18, 32'h1A};
        check_list("wrap8_addr", 1'b0);

        ws_plan = '{0, 2, 0, 0};
        run_burst(1'b1, 32'h100, 3'b011, 3'b010, 4'h2, 5'd0, 0, 0);

        run_burst(1'b1, 32'h3F8, 3'b001, 3'b010, 4'h0, 5'd4, 0, 0);
        ref_q = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
        check_list("incr_1k_addr", 1'b0);
        check("incr_1k_trans", 64'({tlist[0], tlist[1], tlist[2], tlist[3]}), 64'(8'b10_11_10_11));

        run_burst(1'b0, 32'h200, 3'b101, 3'b010, 4'h0, 5'd0, 0, 2);

        // Reset in the middle of a write burst
        cmd_write = 1'b1; cmd_addr = 32'h240; cmd_hburst = 3'b101; cmd_hsize = 3'b010;
        cmd_hprot = 4'hF; cmd_len = 5'd0; wdata = 32'hCAFE_F00D; cmd_valid = 1'b1;
        @(negedge HCLK);
        cmd_valid = 1'b0;
        repeat (3) @(negedge HCLK);
        check("midburst_active", 64'(HTRANS[1]), 64'(1));
        HRESETn = 1'b0;
        #1;
        check("arst_htrans", 64'(HTRANS), 64'(0));
        check("arst_hsel_haddr", 64'({HSEL, HADDR}), 64'(0));
        check("arst_hwdata", 64'(HWDATA), 64'(0));
        check("arst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("arst_pulses", 64'({wdata_pop, done, err}), 64'(0));
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (3) begin
            @(negedge HCLK);
            check("no_done_after_rst", 64'(done), 64'(0));
        end

        for (int k = 0; k < 40; k++) begin : rnd
            logic [2:0]  hb, hs, eff;
            logic [4:0]  len;
            logic [31:0] addr;
            int          eb;
            hb = 3'($urandom_range(0, 7));
            hs = 3'($urandom_range(0, 3));
            if (hs == 3'd3) hs = 3'($urandom_range(3, 7));
            eff  = (hs > 3'b010) ? 3'b010 : hs;
            addr = 32'($urandom_range(0, 4095)) & ~((32'd1 << eff) - 32'd1);
            len  = 5'($urandom_range(0, 20));
            eb   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, beats_of(hb, len))) : 0;
            run_burst(1'($urandom_range(0, 1)), addr, hb, hs, 4'($urandom_range(0, 15)),
                      len, int'($urandom_range(0, 2)), eb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb3lite_burst_master.md
Name: ahb3lite_burst_master

Overview:
- Command-driven AHB3-Lite master sequencer. It turns one burst command (address, size, burst type, direction) into a correctly pipelined AHB-Lite transaction on the shared `bus`.
- It replaces per-beat hand-driven transfers in benches and subsystems.
- Sits between a requester (bench task, DMA front end) and the ahb3lite_if master port.
- It generates HTRANS/HADDR sequencing, wrap/increment addressing, wait-state stalls and error abort.

Parameters:
- HADDR_SIZE, 32, address width
- HDATA_SIZE, 32, data width
- MAX_LEN, 16, maximum beat count for undefined-length INCR

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept command
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  HADDR_SIZE  start address, aligned to cmd_hsize
- cmd_hburst  in  3  AHB burst encoding
- cmd_hsize  in  3  beat size, 000..010 only
- cmd_hprot  in  4  HPROT value for whole burst
- cmd_len  in  5  beat count (1..MAX_LEN), used only when cmd_hburst=INCR (001)
- wdata  in  HDATA_SIZE  next write word, FWFT style
- wdata_pop  out  1  wdata consumed this cycle
- rdata  out  HDATA_SIZE  read beat data
- rdata_valid  out  1  rdata valid pulse
- done  out  1  burst complete pulse
- err  out  1  qualifies done: burst ended on ERROR response
- HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK  out  master signals on ahb3lite_if
- HRDATA, HREADY, HRESP  in  slave response signals

Behaviour:
- Reset (async): HTRANS=IDLE(00), HSEL=0, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=0, HMASTLOCK=0, cmd_ready=1, wdata_pop=0, rdata=0, rdata_valid=0, done=0, err=0, FSM=IDLE.
  - Reset mid-burst abandons the burst with no done pulse.
- FSM states:
  - IDLE: cmd_ready=1. A cmd_valid&cmd_ready handshake latches the command and moves to BURST. Next cycle drives HTRANS=NONSEQ, HSEL=1, HADDR=cmd_addr.
  - BURST: address phase of beat n overlaps data phase of beat n-1.
    - Address/control advance only on HREADY=1.
    - HTRANS=SEQ for beats 2..N.
    - After the last address phase is accepted, HTRANS=IDLE, HSEL=0, and the FSM moves to LAST.
  - LAST: waits for HREADY=1 on the final data phase, then pulses done=1 and returns to IDLE (cmd_ready=1 in the same cycle as done).
  - ERR: entered on HRESP=1 with HREADY=0 (first error cycle).
    - Next cycle forces HTRANS=IDLE and cancels remaining beats.
    - Waits for HREADY=1, then pulses done=1 and err=1, and returns to IDLE.
- Beat count N: SINGLE=1, INCR=cmd_len (0 treated as 1), WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
- Address step is 1<<HSIZE.
  - WRAP bursts: boundary = N<<HSIZE. Upper bits above the boundary are held; lower bits wrap modulo the boundary.
  - INCR-family bursts that reach a 1KB boundary (HADDR[9:0] wraps to 0) issue that beat as NONSEQ with HBURST=INCR, then continue SEQ. Total beat count is unchanged.
- Write path:
  - wdata_pop pulses in each cycle a write address phase is accepted (HTRANS active, HREADY=1).
  - HWDATA<=wdata in that same edge, so it is valid for the following data phase and held through wait states.
- Read path: when a read data phase completes (HREADY=1, HRESP=0), the next cycle gives rdata<=HRDATA and rdata_valid=1 for one cycle.
- HREADY=0 freezes HADDR, HTRANS, HWDATA and all counters. No BUSY transfers are ever issued.
- Zero-wait latency: the N-beat burst occupies N+1 bus cycles after the accept cycle; done follows in the next cycle.
- cmd_valid while busy is ignored (cmd_ready=0). Unsupported cmd_hsize (>010) is accepted but clamped to 010.

Test Plan:
- INCR4 word write, addr 0x0, data 1111_1111..4444_4444, HREADY=1 -> HTRANS NONSEQ,SEQ,SEQ,SEQ at HADDR 0,4,8,C; HWDATA 1111_1111..4444_4444 one cycle behind; 4 wdata_pops; done 1 cycle after last data phase, err=0.
- INCR4 word read of the same region -> 4 rdata_valid pulses carrying 1111_1111..4444_4444 in order.
- WRAP4 word read at 0x38 -> HADDR 38,3C,30,34; WRAP8 halfword at 0x1C -> 1C,1E,10,12,14,16,18,1A.
- Slave inserts 2 wait states on beat 2 of an INCR4 write -> HADDR/HTRANS/HWDATA held stable for 2 cycles; no beat lost; done delayed by 2.
- INCR cmd_len=4 word at 0x3F8 -> HADDR 3F8 NONSEQ, 3FC SEQ, 400 NONSEQ, 404 SEQ.
- HRESP ERROR on beat 2 of INCR8 -> HTRANS=IDLE the cycle after the first error cycle; no further beats; done=1 with err=1. Separately, HRESETn low mid-burst -> all outputs return to reset values immediately and no done pulse.
